divclk_strobe: RTL and testbench
================================

# divclk_strobe

Clock-domain consumer for the divided "clock" lines produced by the master clock divider. It resynchronises the slow segment and speed square waves into the 100 MHz clk domain and converts each rising edge into a single-cycle enable strobe. It also selects one speed strobe as the ball-movement enable according to a hit-driven difficulty level, and flags a stalled speed source with a watchdog. All game logic downstream runs on clk gated by these strobes, never on the divided lines directly.

## Interface
- SYNC_STAGES, 2: synchroniser depth per input; minimum 2.
- WDOG_W, 23: watchdog counter width.
- WDOG_LIMIT, 4194304: clk cycles without a ball_tick before stall asserts. This is 2× the slowest speed period of 2^21 cycles.
- clk  in  1  100 MHz master clock.
- clr  in  1  reset, asynchronous, active-high.
- seg_in  in  1  divided segment-refresh square wave, about 381 Hz.
- speed_in  in  4  divided speed square waves; bit 0 slowest (period 2^21 clk), bit 3 fastest (period 2^18 clk).
- hit  in  1  one-cycle pulse: raise difficulty level.
- miss  in  1  one-cycle pulse: return level to 0.
- seg_tick  out  1  one-cycle strobe per seg_in rising edge.
- speed_tick  out  4  one-cycle strobe per rising edge of the matching speed_in bit.
- ball_tick  out  1  equals speed_tick[level], registered.
- level  out  2  current difficulty, 0..3.
- stall  out  1  watchdog flag, held until recovered.

## Operation
- Five independent channels (seg_in, speed_in[3:0]). Each channel has:
  - a SYNC_STAGES flop chain,
  - a prev flop,
  - an armed bit.
- Strobe rule: strobe = armed & sync_out & ~prev. The strobe is registered.
- Arming:
  - armed clears on reset.
  - armed sets once the chain has filled (SYNC_STAGES+1 edges after clr deasserts).
  - While unarmed, prev tracks sync_out.
  - Consequence: an input already high at reset release produces no strobe until it falls and rises again.
- Level register, saturating:
  - hit increments level, saturating at 3.
  - miss forces level to 0.
  - hit and miss in the same cycle: miss wins.
  - hit at level 3: no change, no side effects.
- ball_tick is selected from the per-channel strobes, never from the raw inputs. A level change therefore cannot create a spurious or double strobe.
  - A level change takes effect for strobes generated on the cycle after the update.
  - A strobe on the old channel in the update cycle itself is still delivered.
- Watchdog FSM, states ARM, RUN, STALL:
  - ARM: entered on reset. Counter held at 0, stall=0. Moves to RUN when the speed channels are armed.
  - RUN: counter increments each cycle and saturates at 2^WDOG_W−1.
    - Counter clears on ball_tick.
    - Counter clears on any level change, since the period changes.
    - Counter reaching WDOG_LIMIT−1 moves to STALL.
  - STALL: stall=1, counter held.
    - ball_tick moves the FSM back to RUN with counter 0. stall drops the cycle after ball_tick.
    - A level change alone does not clear stall.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). In-flight edges are discarded.

## Timing
- Reset values: seg_tick=0, speed_tick=0, ball_tick=0, level=0, stall=0. Sync chains, prev and armed are all 0. FSM is in ARM.
- Strobe latency: a rising input first sampled high at clk edge k gives a strobe high from edge k+SYNC_STAGES to edge k+SYNC_STAGES+1. Width is exactly 1 cycle.
- ball_tick is coincident with speed_tick[level]. No extra latency.
- level updates on the clk edge where hit or miss is sampled. It is visible the following cycle.
- stall rises on the edge where the counter reaches WDOG_LIMIT−1. At the default, that is 4194304 cycles after the last ball_tick or level change.
- Input high or low time shorter than 2 clk cycles is unsupported and may be missed. This cannot occur with divider outputs.

## Structure
- Shared package holds:
  - speed channel indices (SPEED_SLOW=0 … SPEED_FAST=3);
  - the level type (2-bit);
  - watchdog state encoding;
  - the default WDOG_LIMIT.
- One sub-module, edge_strobe: a single-channel synchroniser, arming logic and rising-edge strobe, parameterised by SYNC_STAGES. It is instantiated five times.
- Level register, ball_tick mux and watchdog FSM live in the top module.

## Test plan
- Reset with all inputs high, then release clr and hold inputs high for 100 cycles.
  - Required: no strobes.
  - Drop speed_in[0] for 4 cycles, then raise it: exactly one speed_tick[0], 3 cycles after the rise with SYNC_STAGES=2.
- Drive speed_in[3:0] and seg_in from a model divider (periods 2^18..2^21 and 2^18).
  - Required: over 2^22 cycles, counts of 16, 8, 4, 2 for speed_tick[3..0] and 16 for seg_tick, each strobe 1 cycle wide.
- hit ×5.
  - Required: level = 1, 2, 3, 3, 3.
- hit and miss in the same cycle at level 2.
  - Required: level = 0.
  - ball_tick then follows speed_tick[0] only.
- Toggle level between 1 and 2 every cycle during a speed edge window.
  - Required: no ball_tick wider than 1 cycle and no ball_tick without a matching speed_tick.
- Freeze speed_in[0] low at level 0.
  - Required: stall=1 exactly 4194304 cycles after the last ball_tick.
  - Resume the toggle: stall=0 the cycle after the next ball_tick.
  - Assert clr mid-count: stall and counter return to 0 immediately.

Source files
------------

// File: rtl/divclk_strobe_pkg.sv
// rtl/divclk_strobe_pkg.sv - shared types and constants for the divided-clock strobe block
package divclk_strobe_pkg;

  localparam int SPEED_SLOW = 0;
  localparam int SPEED_FAST = 3;
  localparam int NUM_SPEED  = SPEED_FAST - SPEED_SLOW + 1;

  // Twice the slowest speed period of 2^21 clk cycles.
  localparam int WDOG_LIMIT_DEF = 4194304;

  typedef logic [1:0] level_t;
  localparam level_t LEVEL_MAX = 2'd3;

  typedef enum logic [1:0] {
    WD_ARM   = 2'd0,
    WD_RUN   = 2'd1,
    WD_STALL = 2'd2
  } wdog_state_t;

  // miss dominates hit; hit saturates at LEVEL_MAX
  function automatic level_t level_next(input level_t cur, input logic up, input logic clear);
    if (clear) return '0;
    if (up && cur != LEVEL_MAX) return cur + 2'd1;
    return cur;
  endfunction

endpackage

// File: rtl/edge_strobe.sv
// rtl/edge_strobe.sv - one-channel synchroniser with arming and registered rising-edge strobe
module edge_strobe #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic strobe,
  output logic strobe_next,
  output logic armed
);

  localparam int CW = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [CW-1:0]          fill;

  // prev always follows the chain, so a level already high when arming completes never strobes
  assign strobe_next = armed & sync[SYNC_STAGES-1] & ~prev;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync   <= '0;
      prev   <= 1'b0;
      fill   <= '0;
      armed  <= 1'b0;
      strobe <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], d};
      prev   <= sync[SYNC_STAGES-1];
      strobe <= strobe_next;
      if (!armed) begin
        if (fill == CW'(SYNC_STAGES)) armed <= 1'b1;
        else                          fill  <= fill + 1'b1;
      end
    end
  end

endmodule

// File: rtl/divclk_strobe.sv
// rtl/divclk_strobe.sv - divided-line strobes, difficulty-selected ball tick and stall watchdog
module divclk_strobe
  import divclk_strobe_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WDOG_W      = 23,
  parameter int WDOG_LIMIT  = WDOG_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 seg_in,
  input  logic [NUM_SPEED-1:0] speed_in,
  input  logic                 hit,
  input  logic                 miss,
  output logic                 seg_tick,
  output logic [NUM_SPEED-1:0] speed_tick,
  output logic                 ball_tick,
  output logic [1:0]           level,
  output logic                 stall
);

  localparam logic [WDOG_W-1:0] LIM_M1  = WDOG_W'(WDOG_LIMIT - 1);
  localparam logic [WDOG_W-1:0] CNT_MAX = '1;

  logic [NUM_SPEED-1:0] spd_next;
  logic [NUM_SPEED-1:0] spd_armed;
  logic                 seg_next;
  logic                 seg_armed;
  logic                 unused_seg;

  edge_strobe #(.SYNC_STAGES(SYNC_STAGES)) u_seg (
    .clk(clk), .clr(clr), .d(seg_in),
    .strobe(seg_tick), .strobe_next(seg_next), .armed(seg_armed)
  );

  for (genvar i = 0; i < NUM_SPEED; i++) begin : g_speed
    edge_strobe #(.SYNC_STAGES(SYNC_STAGES)) u_spd (
      .clk(clk), .clr(clr), .d(speed_in[i]),
      .strobe(speed_tick[i]), .strobe_next(spd_next[i]), .armed(spd_armed[i])
    );
  end

  assign unused_seg = seg_next ^ seg_armed;

  level_t lvl_n;
  logic   lvl_chg;

  assign lvl_n   = level_next(level, hit, miss);
  assign lvl_chg = (lvl_n != level);

  // ball_tick registers the same pre-strobe as speed_tick, using the level before any update
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      level     <= '0;
      ball_tick <= 1'b0;
    end else begin
      level     <= lvl_n;
      ball_tick <= spd_next[level];
    end
  end

  wdog_state_t       st, st_n;
  logic [WDOG_W-1:0] cnt, cnt_n;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st  <= WD_ARM;
      cnt <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    case (st)
      WD_ARM: begin
        cnt_n = '0;
        if (&spd_armed) st_n = WD_RUN;
      end
      WD_RUN: begin
        if (ball_tick || lvl_chg) begin
          cnt_n = '0;
        end else begin
          if (cnt != CNT_MAX) cnt_n = cnt + 1'b1;
          if (cnt_n == LIM_M1) st_n = WD_STALL;
        end
      end
      WD_STALL: begin
        if (ball_tick) begin
          st_n  = WD_RUN;
          cnt_n = '0;
        end
      end
      default: begin
        st_n  = WD_ARM;
        cnt_n = '0;
      end
    endcase
  end

  assign stall = (st == WD_STALL);

endmodule

// File: tb/tb_divclk_strobe.sv
// tb/tb_divclk_strobe.sv - scoreboard bench for divclk_strobe with a behavioural strobe/level/watchdog model
module tb_divclk_strobe;

  localparam int S   = 2;
  localparam int WW  = 10;
  localparam int LIM = 512;

  logic       clk = 1'b0;
  logic       clr;
  logic       seg_in;
  logic [3:0] speed_in;
  logic       hit, miss;
  logic       seg_tick;
  logic [3:0] speed_tick;
  logic       ball_tick;
  logic [1:0] level;
  logic       stall;

  divclk_strobe #(.SYNC_STAGES(S), .WDOG_W(WW), .WDOG_LIMIT(LIM)) dut (
    .clk(clk), .clr(clr), .seg_in(seg_in), .speed_in(speed_in),
    .hit(hit), .miss(miss), .seg_tick(seg_tick), .speed_tick(speed_tick),
    .ball_tick(ball_tick), .level(level), .stall(stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // expected strobe cycles per channel: 0..3 speed, 4 seg
  int         exp_q[5][$];
  int         lvl_cyc_q[$];
  logic [1:0] lvl_val_q[$];
  logic       in_rst;
  int         m_evt;
  logic       m_stall;
  logic [1:0] exp_level;
  logic [1:0] mdl_level;
  logic [4:0] cur_in;
  int         obs_cnt[5];
  int         dcnt;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] eh;
    logic [4:0] act;
    logic [1:0] lprev;
    act = {seg_tick, speed_tick};
    if (cyc == 0) begin
      eh = '0;
    end else if (in_rst) begin
      check("rst_ticks", int'(act), 0);
      check("rst_ball", int'(ball_tick), 0);
      check("rst_level", int'(level), 0);
      check("rst_stall", int'(stall), 0);
    end else begin
      for (int ch = 0; ch < 5; ch++) begin
        while (exp_q[ch].size() > 0 && exp_q[ch][0] < cyc) begin
          check($sformatf("missed_tick%0d", ch), 0, 1);
          void'(exp_q[ch].pop_front());
        end
        eh[ch] = (exp_q[ch].size() > 0 && exp_q[ch][0] == cyc);
      end
      lprev = exp_level;
      if (lvl_cyc_q.size() > 0 && lvl_cyc_q[0] == cyc) begin
        if (lvl_val_q[0] != exp_level && !m_stall) m_evt = cyc - 1;
        exp_level = lvl_val_q[0];
        void'(lvl_cyc_q.pop_front());
        void'(lvl_val_q.pop_front());
      end
      for (int ch = 0; ch < 5; ch++) begin
        check($sformatf("tick%0d", ch), int'(act[ch]), int'(eh[ch]));
        if (eh[ch]) void'(exp_q[ch].pop_front());
        if (act[ch]) obs_cnt[ch]++;
      end
      check("ball_tick", int'(ball_tick), int'(eh[lprev]));
      check("level", int'(level), int'(exp_level));
      if (!m_stall && (cyc - m_evt) >= LIM) m_stall = 1'b1;
      check("stall", int'(stall), int'(m_stall));
      if (eh[lprev]) begin
        m_evt   = cyc;
        m_stall = 1'b0;
      end
    end
  end

  // one stimulus cycle: inputs change 2 time units after the edge
  task automatic drive(input logic [4:0] v, input logic h, input logic m);
    @(posedge clk);
    #2;
    for (int ch = 0; ch < 5; ch++)
      if (v[ch] && !cur_in[ch]) exp_q[ch].push_back(cyc + 1 + S);
    cur_in   = v;
    speed_in = v[3:0];
    seg_in   = v[4];
    hit      = h;
    miss     = m;
    if (h || m) begin
      if (m)                      mdl_level = 2'd0;
      else if (mdl_level != 2'd3) mdl_level = mdl_level + 2'd1;
      lvl_cyc_q.push_back(cyc + 1);
      lvl_val_q.push_back(mdl_level);
    end
  endtask

  // model divider: speed[k] has period 2^(8-k), seg period 2^5
  function automatic logic [4:0] divv(input int n, input logic f0);
    logic [31:0] u;
    u = n;
    return {u[4], u[4], u[5], u[6], u[7] & ~f0};
  endfunction

  task automatic div_one(input logic f0, input logic h, input logic m);
    drive(divv(dcnt, f0), h, m);
    dcnt++;
  endtask

  task automatic div_run(input int n, input logic f0, input int mode);
    logic h, m;
    for (int i = 0; i < n; i++) begin
      h = 1'b0;
      m = 1'b0;
      if (mode == 1) begin
        h = ($urandom_range(0, 1) == 1);
        m = ($urandom_range(0, 3) == 0);
      end else if (mode == 2) begin
        h = ($urandom_range(0, 15) == 0);
        m = ($urandom_range(0, 31) == 0);
      end
      div_one(f0, h, m);
    end
  endtask

  task automatic assert_clr();
    @(posedge clk);
    #2;
    clr    = 1'b1;
    in_rst = 1'b1;
    for (int ch = 0; ch < 5; ch++) exp_q[ch].delete();
    lvl_cyc_q.delete();
    lvl_val_q.delete();
    mdl_level = 2'd0;
    exp_level = 2'd0;
    m_stall   = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;
    #1;
    check("clr_async_stall", int'(stall), 0);
    check("clr_async_level", int'(level), 0);
    check("clr_async_ticks", int'({seg_tick, speed_tick, ball_tick}), 0);
  endtask

  task automatic release_clr();
    @(posedge clk);
    #2;
    clr    = 1'b0;
    in_rst = 1'b0;
    m_evt  = cyc + S + 1;
  endtask

  initial begin
    int base[5];
    int want[5];
    logic stalled_before_clr;
    want = '{2, 4, 8, 16, 16};
    clr       = 1'b1;
    in_rst    = 1'b1;
    cur_in    = 5'h1F;
    speed_in  = 4'hF;
    seg_in    = 1'b1;
    hit       = 1'b0;
    miss      = 1'b0;
    mdl_level = 2'd0;
    exp_level = 2'd0;
    m_stall   = 1'b0;
    m_evt     = 0;
    dcnt      = 0;
    for (int ch = 0; ch < 5; ch++) obs_cnt[ch] = 0;
    repeat (3) @(posedge clk);
    release_clr();

    // inputs high through reset release: no strobes; then one clean speed0 edge
    repeat (100) drive(5'h1F, 1'b0, 1'b0);
    repeat (4) drive(5'h1E, 1'b0, 1'b0);
    repeat (6) drive(5'h1F, 1'b0, 1'b0);

    for (int ch = 0; ch < 5; ch++) base[ch] = obs_cnt[ch];
    dcnt = 0;
    div_run(515, 1'b0, 0);
    for (int ch = 0; ch < 5; ch++)
      check($sformatf("div_count%0d", ch), obs_cnt[ch] - base[ch], want[ch]);

    // saturating hits, then hit+miss together at level 2
    div_run(5, 1'b0, 3);
    repeat (5) div_one(1'b0, 1'b1, 1'b0);
    div_one(1'b0, 1'b0, 1'b1);
    div_one(1'b0, 1'b1, 1'b0);
    div_one(1'b0, 1'b1, 1'b0);
    div_one(1'b0, 1'b1, 1'b1);
    div_run(600, 1'b0, 0);

    // level churning every cycle across speed edges, then sparse random play
    div_run(300, 1'b0, 1);
    div_run(400, 1'b0, 2);

    // freeze slowest channel at level 0 until stall, then resume
    div_one(1'b0, 1'b0, 1'b1);
    div_run(LIM + 40, 1'b1, 0);
    check("stall_after_freeze", int'(stall), 1);
    div_run(300, 1'b0, 0);
    check("stall_after_resume", int'(stall), 0);

    // reset while stalled, then confirm the counter restarted from zero
    div_run(LIM + 40, 1'b1, 0);
    stalled_before_clr = stall;
    check("stall_before_clr", int'(stalled_before_clr), 1);
    assert_clr();
    repeat (3) @(posedge clk);
    release_clr();
    repeat (12) drive(cur_in, 1'b0, 1'b0);
    div_run(LIM + 40, 1'b1, 0);
    div_run(300, 1'b0, 2);
    repeat (10) drive(cur_in, 1'b0, 1'b0);

    for (int ch = 0; ch < 5; ch++)
      check($sformatf("leftover_tick%0d", ch), exp_q[ch].size(), 0);
    check("leftover_level", lvl_cyc_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
